// File: rtl/pl_ctrl_pkg.sv
// pl_ctrl_pkg: state type and counter sizing shared by the stall controller slice
package pl_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MD_BUSY, MEM_WAIT} pl_ctrl_state_t;
  function automatic int cnt_width(input int mult_lat, input int div_lat);
    int m;
    m = mult_lat > div_lat ? mult_lat : div_lat;
    return m > 2 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/pl_stall_controller_if.sv
// pl_stall_controller_if: hazard inputs and pipeline-register controls of the stall controller
interface pl_stall_controller_if;
  logic load_use_hazard, branch_taken, ex_md_start, ex_md_is_div, mem_req, mem_ready;
  logic pc_write, IF_ID_write, ID_EX_write, EX_MEM_write;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, md_done;
  modport master (
    output load_use_hazard, branch_taken, ex_md_start, ex_md_is_div, mem_req, mem_ready,
    input pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
    input IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, md_done
  );
  modport slave (
    input load_use_hazard, branch_taken, ex_md_start, ex_md_is_div, mem_req, mem_ready,
    output pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
    output IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, md_done
  );
endinterface

// File: rtl/pl_md_counter.sv
// pl_md_counter: loadable down-counter with zero flag tracking mult/div occupancy of EX
module pl_md_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/pl_stall_controller.sv
// pl_stall_controller: prioritised stall/flush sequencer for the 5-stage pipeline
// Optional PL_CTRL_STATS_EN adds stall_cnt/flush_cnt statistics outputs.
import pl_ctrl_pkg::*;
module pl_stall_controller #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef PL_CTRL_STATS_EN
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
`endif
  pl_stall_controller_if.slave  s
);
  localparam int W = cnt_width(MULT_LAT, DIV_LAT);
  localparam logic [W-1:0] MULT_LD = W'(MULT_LAT - 2);
  localparam logic [W-1:0] DIV_LD  = W'(DIV_LAT - 2);
  pl_ctrl_state_t state, next;
  logic load, dec, zero;
  logic [W-1:0] load_val;
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else state <= next;
  end
  pl_md_counter #(.W(W)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .dec(dec), .load_val(load_val), .zero(zero)
  );
  assign load_val = s.ex_md_is_div ? DIV_LD : MULT_LD;
  always_comb begin
    next = state;
    load = 1'b0;
    dec = 1'b0;
    {s.pc_write, s.IF_ID_write, s.ID_EX_write, s.EX_MEM_write} = 4'b1111;
    {s.IF_ID_flush, s.ID_EX_flush, s.EX_MEM_flush, s.MEM_WB_flush} = 4'b0000;
    s.md_done = 1'b0;
    if (rst) begin
      {s.IF_ID_flush, s.ID_EX_flush, s.EX_MEM_flush, s.MEM_WB_flush} = 4'b1111;
      next = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (s.mem_req && !s.mem_ready) begin
            {s.pc_write, s.IF_ID_write, s.ID_EX_write, s.EX_MEM_write} = 4'b0000;
            s.MEM_WB_flush = 1'b1;
            next = MEM_WAIT;
          end else if (s.ex_md_start) begin
            {s.pc_write, s.IF_ID_write, s.ID_EX_write} = 3'b000;
            s.EX_MEM_flush = 1'b1;
            load = 1'b1;
            next = MD_BUSY;
          end else if (s.load_use_hazard) begin
            {s.pc_write, s.IF_ID_write} = 2'b00;
            s.ID_EX_flush = 1'b1;
          end else if (s.branch_taken) begin
            s.IF_ID_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!s.mem_ready) begin
            {s.pc_write, s.IF_ID_write, s.ID_EX_write, s.EX_MEM_write} = 4'b0000;
            s.MEM_WB_flush = 1'b1;
          end else if (s.ex_md_start) begin
            {s.pc_write, s.IF_ID_write, s.ID_EX_write} = 3'b000;
            s.EX_MEM_flush = 1'b1;
            load = 1'b1;
            next = MD_BUSY;
          end else begin
            next = RUN;
          end
        end
        MD_BUSY: begin
          if (!zero) begin
            {s.pc_write, s.IF_ID_write, s.ID_EX_write} = 3'b000;
            s.EX_MEM_flush = 1'b1;
            dec = 1'b1;
          end else begin
            s.md_done = 1'b1;
            next = RUN;
          end
        end
        default: next = RUN;
      endcase
    end
  end
`ifdef PL_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, !s.pc_write};
      flush_cnt <= flush_cnt + {31'd0, s.IF_ID_flush};
    end
  end
`endif
endmodule

// File: tb/tb_pl_stall_controller.sv
// tb_pl_stall_controller: directed vectors with a scoreboard queue and negedge monitor
module tb_pl_stall_controller;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;
  localparam logic [8:0] NORM = 9'b1111_0000_0;
  localparam logic [8:0] RSTV = 9'b1111_1111_0;
  localparam logic [8:0] FRZ  = 9'b0000_0001_0;
  localparam logic [8:0] FF   = 9'b0001_0010_0;
  localparam logic [8:0] LU   = 9'b0011_0100_0;
  localparam logic [8:0] BR   = 9'b1111_1000_0;
  localparam logic [8:0] DONE = 9'b1111_0000_1;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  string name_q[$];
  pl_stall_controller_if bus ();
`ifdef PL_CTRL_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] s0;
`endif
  pl_stall_controller #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PL_CTRL_STATS_EN
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
`endif
    .s(bus.slave)
  );
  always #5 clk = ~clk;
  wire [8:0] act = {bus.pc_write, bus.IF_ID_write, bus.ID_EX_write, bus.EX_MEM_write,
                    bus.IF_ID_flush, bus.ID_EX_flush, bus.EX_MEM_flush, bus.MEM_WB_flush, bus.md_done};
  // inputs: {rst, load_use, branch, md_start, md_is_div, mem_req, mem_ready}
  task automatic cyc(input logic [6:0] v, input logic [8:0] e, input string n);
    @(posedge clk);
    #1;
    {rst, bus.load_use_hazard, bus.branch_taken, bus.ex_md_start, bus.ex_md_is_div,
     bus.mem_req, bus.mem_ready} = v;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", n, act, e);
      end
    end
  end
  initial begin
    rst = 1'b1;
    {bus.load_use_hazard, bus.branch_taken, bus.ex_md_start, bus.ex_md_is_div,
     bus.mem_req, bus.mem_ready} = '0;
    cyc(7'b1000000, RSTV, "reset");
    cyc(7'b1000000, RSTV, "reset");
    cyc(7'b0000000, NORM, "idle");
    for (int i = 0; i < MULT_LAT - 1; i++) cyc(7'b0001000, FF, "mult_busy");
    cyc(7'b0001000, DONE, "mult_done");
    cyc(7'b0000000, NORM, "after_mult");
`ifdef PL_CTRL_STATS_EN
    s0 = stall_cnt;
`endif
    for (int i = 0; i < 3; i++) cyc(7'b0000010, FRZ, "mem_wait");
    cyc(7'b0000011, NORM, "mem_release");
    cyc(7'b0000000, NORM, "after_mem");
`ifdef PL_CTRL_STATS_EN
    checks++;
    if (stall_cnt - s0 !== 32'd3) begin
      errors++;
      $display("FAIL stall_cnt_delta: got %0d expected 3", stall_cnt - s0);
    end
`endif
    cyc(7'b0001010, FRZ, "mem_md_wait");
    cyc(7'b0001010, FRZ, "mem_md_wait");
    for (int i = 0; i < MULT_LAT - 1; i++) cyc(7'b0001011, FF, "mem_md_busy");
    cyc(7'b0001000, DONE, "mem_md_done");
    cyc(7'b0000000, NORM, "after_mem_md");
    cyc(7'b0110000, LU, "lu_beats_branch");
    cyc(7'b0010000, BR, "branch_after_lu");
    cyc(7'b0000000, NORM, "idle2");
    cyc(7'b0010000, BR, "branch_alone");
    cyc(7'b0100000, LU, "lu_alone");
    cyc(7'b0000000, NORM, "lu_one_cycle");
    for (int i = 0; i < 10; i++) cyc(7'b0001100, FF, "div_busy");
    cyc(7'b1001100, RSTV, "div_mid_reset");
    for (int i = 0; i < 4; i++) cyc(7'b0000000, NORM, "post_reset_no_done");
    for (int i = 0; i < DIV_LAT - 1; i++) cyc(7'b0001100, FF, "div_full_busy");
    cyc(7'b0001100, DONE, "div_done");
    cyc(7'b0000000, NORM, "after_div");
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pl_stall_controller.md
# pl_stall_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the load-use hazard flag, multi-cycle mult/div occupancy of EX, data-memory wait states and taken-branch redirects. From these it drives one write-enable or flush per pipeline register, so that stalls are applied in a fixed priority order. It sits beside the hazard detection and forwarding logic and replaces their direct wiring to PC and IF/ID.

## Interface
- `MULT_LAT`, default 4: total cycles a mult instruction occupies EX; must be ≥ 2.
- `DIV_LAT`, default 32: total cycles a div instruction occupies EX; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_use_hazard` in 1: load-use stall request from hazard detection.
- `branch_taken` in 1: branch in ID resolved taken.
- `ex_md_start` in 1: level signal; EX holds a mult/div instruction.
- `ex_md_is_div` in 1: qualifies `ex_md_start`; 1 = div, 0 = mult.
- `mem_req` in 1: MEM stage issues a data-memory access.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: PC update enable.
- `IF_ID_write`, `ID_EX_write`, `EX_MEM_write` out 1 each: pipeline register enables.
- `IF_ID_flush`, `ID_EX_flush`, `EX_MEM_flush`, `MEM_WB_flush` out 1 each: load a bubble into the register.
- `md_done` out 1: final EX cycle of mult/div; EX commits HI/LO.

## Operation
- FSM states: `RUN`, `MD_BUSY`, `MEM_WAIT`. Down-counter width is `$clog2(DIV_LAT)`.
- Outputs are Mealy (state plus current inputs). Default output set ("normal"): all `*_write`=1, all flushes=0, `md_done`=0.
- Priorities in `RUN`, highest first:
  1. `mem_req && !mem_ready`: freeze. `pc_write`, `IF_ID_write`, `ID_EX_write` and `EX_MEM_write` are 0, and `MEM_WB_flush`=1. Next state is `MEM_WAIT`.
  2. `ex_md_start`: front freeze. `pc_write`, `IF_ID_write` and `ID_EX_write` are 0, and `EX_MEM_flush`=1. Load the counter with LAT−2, where LAT is `DIV_LAT` if `ex_md_is_div` else `MULT_LAT`. Next state is `MD_BUSY`.
  3. `load_use_hazard`: `pc_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1. State stays `RUN`. `branch_taken` is ignored in this cycle because its operands are not yet valid.
  4. `branch_taken`: `IF_ID_flush`=1 and `pc_write`=1.
- `MEM_WAIT`:
  - While `!mem_ready`: same freeze as priority 1.
  - On `mem_ready` with `!ex_md_start`: normal outputs; next state `RUN`.
  - On `mem_ready` with `ex_md_start`: MEM drains normally, with `EX_MEM_flush`=1 and a front freeze. Load the counter as above; next state `MD_BUSY`.
- `MD_BUSY`:
  - While counter ≠ 0: front freeze, `EX_MEM_flush`=1, counter decrements.
  - When counter = 0: `md_done`=1, normal outputs, next state `RUN`.
- In `MD_BUSY` and `MEM_WAIT`, `load_use_hazard` and `branch_taken` are ignored. ID is frozen, so they are re-evaluated after release.
- `mem_req` is ignored in `MD_BUSY`, because MEM holds bubbles there.

## Timing
- `rst`=1 at a clock edge sets state to `RUN` and the counter to 0. This holds from any state, including mid-wait.
- While `rst`=1, outputs are: all `*_write`=1, all `*_flush`=1, `md_done`=0.
- After reset, with inputs low, outputs are normal.
- A mult/div keeps EX for exactly LAT cycles, counting from the first cycle in which it is seen in `RUN`. `md_done` is asserted in the last of those cycles, and in that cycle `pc_write`=1.
- A memory wait freezes for one cycle per `!mem_ready` cycle. The release happens in the same cycle that `mem_ready`=1.
- A load-use stall lasts exactly one cycle.

## Configuration
- `PL_CTRL_STATS_EN` defined adds two outputs:
  - `stall_cnt` out 32: increments every cycle with `pc_write`=0.
  - `flush_cnt` out 32: increments every cycle with `IF_ID_flush`=1 outside reset.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package `pl_ctrl_pkg` holds the state typedef `pl_ctrl_state_t` (`RUN`, `MD_BUSY`, `MEM_WAIT`) and the function computing counter width from the latency parameters.
- Sub-module `pl_md_counter` provides load, decrement and zero flag.

## Test plan
- Reset mid-`MD_BUSY` (`DIV_LAT`=32, cycle 10) → next cycle state is `RUN` and outputs are normal; no `md_done` occurs.
- `ex_md_start`=1, `ex_md_is_div`=0, `MULT_LAT`=4, starting at cycle 0:
  - `pc_write`=0 in cycles 0–2.
  - `md_done`=1 together with `pc_write`=1 in cycle 3.
  - `EX_MEM_flush`=1 in cycles 0–2.
- `mem_req`=1 with `mem_ready` low for 3 cycles, then high:
  - `MEM_WB_flush`=1 for 3 cycles.
  - Release on the 4th cycle.
  - `stall_cnt` advances by 3 (with `PL_CTRL_STATS_EN`).
- `mem_req`, `mem_ready`=0 and `ex_md_start`=1 together, then `mem_ready`=1 after 2 cycles → memory freeze for 2 cycles, then `MD_BUSY` for the full LAT with no lost instruction.
- `load_use_hazard`=1 and `branch_taken`=1 in the same cycle → `ID_EX_flush`=1, `IF_ID_flush`=0, `pc_write`=0. Next cycle, with `branch_taken`=1 → `IF_ID_flush`=1.
- `branch_taken`=1 alone → `IF_ID_flush`=1, `pc_write`=1, no other flush asserted.
